boruss_fetch: RTL and testbench

BORUSS_FETCH -- requirements
Module: boruss_fetch

---
 rtl/boruss_pkg.sv | 27 ++
 rtl/boruss_fetch_len.sv | 11 +
 rtl/boruss_fetch.sv | 135 +++++++++++++
 tb/tb_boruss_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/boruss_pkg.sv
// Shared definitions for the BORUSS fetch/decode path: opcode constants,
// fetch FSM encoding, a debug view of the fetch state and the length helper.
package boruss_pkg;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_LOAD_IMM = 8'h01;
  localparam logic [7:0] OP_SHL      = 8'h60;
  localparam logic [7:0] OP_JMP      = 8'h80;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_ARG   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    fetch_state_e state;
    logic         wrapped;
  } fetch_dbg_t;

  // Only LOAD_IMM and JMP carry an immediate byte; everything else is one byte.
  function automatic logic op_has_operand(input logic [7:0] opcode);
    return (opcode == OP_LOAD_IMM) || (opcode == OP_JMP);
  endfunction

endpackage

// File: rtl/boruss_fetch_len.sv
// Combinational instruction-length decode: flags opcodes followed by an operand byte.
module boruss_fetch_len
  import boruss_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       two_byte
);

  assign two_byte = op_has_operand(opcode);

endmodule

// File: rtl/boruss_fetch.sv
// Byte-serial instruction fetch: assembles 1/2-byte instructions from a combinational ROM.
// Optional macro BORUSS_FETCH_WRAP_TRAP_EN turns a PC wrap into a sticky fault.
module boruss_fetch
  import boruss_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic [7:0] instr_pc,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  output logic       fetch_fault,
  output fetch_dbg_t dbg
);

  // Handshake: instr_valid is high only in S_HOLD and the presented fields are
  // frozen there; a transfer happens on any cycle with instr_valid && instr_ready.
  // instr_ready is ignored while instr_valid is low.

  fetch_state_e state;
  fetch_state_e state_next;
  logic [7:0]   pc;
  logic [7:0]   pc_inc;
  logic         pc_carry;
  logic         wrapped;
  logic         two_byte;
  logic         redirect;
  logic         fault_on_op;
  logic         fault_on_arg;

  boruss_fetch_len u_len (
    .opcode   (rom_data),
    .two_byte (two_byte)
  );

  assign {pc_carry, pc_inc} = {1'b0, pc} + 9'd1;
  assign rom_address        = pc;
  assign redirect           = jump_en && (state != S_FAULT);

`ifdef BORUSS_FETCH_WRAP_TRAP_EN
  // A fetch about to start from a wrapped PC is diverted into the fault state.
  assign fault_on_op  = wrapped;
  assign fault_on_arg = pc_carry;
`else
  assign fault_on_op  = 1'b0;
  assign fault_on_arg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_OP: begin
        if (two_byte) begin
          state_next = fault_on_arg ? S_FAULT : S_ARG;
        end else begin
          state_next = S_HOLD;
        end
      end
      S_ARG:   state_next = S_HOLD;
      S_HOLD: begin
        if (instr_ready) begin
          state_next = fault_on_op ? S_FAULT : S_OP;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_OP;
    endcase
    if (redirect) begin
      state_next = S_OP;
    end
  end

  always_comb begin
    instr_valid = (state == S_HOLD);
`ifdef BORUSS_FETCH_WRAP_TRAP_EN
    fetch_fault = (state == S_FAULT);
`else
    fetch_fault = 1'b0;
`endif
    dbg.state   = state;
    dbg.wrapped = wrapped;
  end

  // PC and instruction registers; a redirect wins over the byte being fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      wrapped       <= 1'b0;
      instr_opcode  <= OP_NOP;
      instr_operand <= 8'h00;
      instr_pc      <= 8'h00;
    end else if (redirect) begin
      pc      <= jump_target;
      wrapped <= 1'b0;
    end else begin
      case (state)
        S_OP: begin
          instr_opcode <= rom_data;
          instr_pc     <= pc;
          pc           <= pc_inc;
          if (pc_carry) begin
            wrapped <= 1'b1;
          end
          if (!two_byte) begin
            instr_operand <= 8'h00;
          end
        end
        S_ARG: begin
          instr_operand <= rom_data;
          pc            <= pc_inc;
          if (pc_carry) begin
            wrapped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_fetch.sv
// Bench for boruss_fetch: per-cycle vector table plus wrap and JMP-loop sequences.
// Build with BORUSS_FETCH_WRAP_TRAP_EN to check the wrap-trap variant.
module tb_boruss_fetch;
  import boruss_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       jump_en = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       fetch_fault;
  fetch_dbg_t dbg;

  logic [7:0] rom [0:255];
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       ready;
    logic       jen;
    logic [7:0] jtgt;
    logic       ev;
    logic [7:0] eop;
    logic [7:0] earg;
    logic [7:0] epc;
  } vec_t;

  vec_t tbl [23];

  assign rom_data = rom[rom_address];

  boruss_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_pc      (instr_pc),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .fetch_fault   (fetch_fault),
    .dbg           (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    jump_en = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h01; rom[8'h01] = 8'h05; rom[8'h02] = 8'h60; rom[8'h03] = 8'h60;
    rom[8'h04] = 8'h01; rom[8'h05] = 8'h07; rom[8'h10] = 8'h60;

    //          rst ready jen jtgt   ev  op     arg    pc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h05, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h05, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h60, 8'h00, 8'h02};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h60, 8'h00, 8'h02};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h60, 8'h00, 8'h03};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h60, 8'h00, 8'h03};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h60, 8'h00, 8'h03};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'h01, 8'h00, 8'h04};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 8'h04};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h60, 8'h00, 8'h10};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h60, 8'h00, 8'h10};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 8'h01, 8'h05, 8'h00};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h05, 8'h00};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h06};

    // reset preamble
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'd0, dbg.state}, {30'd0, S_OP});
    check("rst_wrapped", {31'd0, dbg.wrapped}, 32'd0);
    check("rst_rom_address", {24'd0, rom_address}, 32'h00);

    // table: drive row i and check the outputs visible in that cycle
    for (int i = 0; i < 23; i++) begin
      if (i > 0) @(negedge clk);
      rst = tbl[i].rst;
      instr_ready = tbl[i].ready;
      jump_en = tbl[i].jen;
      jump_target = tbl[i].jtgt;
      check($sformatf("row%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].ev});
      check($sformatf("row%0d_opcode", i), {24'd0, instr_opcode}, {24'd0, tbl[i].eop});
      check($sformatf("row%0d_operand", i), {24'd0, instr_operand}, {24'd0, tbl[i].earg});
      check($sformatf("row%0d_pc", i), {24'd0, instr_pc}, {24'd0, tbl[i].epc});
      check($sformatf("row%0d_fault", i), {31'd0, fetch_fault}, 32'd0);
    end

    // PC wrap: one-byte NOPs from FE through FF
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    reset_dut();
    jump_en = 1'b1;
    jump_target = 8'hFE;
    @(negedge clk);
    jump_en = 1'b0;
    instr_ready = 1'b1;
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
`ifndef BORUSS_FETCH_WRAP_TRAP_EN
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
`endif
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("wrap_unexpected_instr_pc", {24'd0, instr_pc}, 32'hFFFF_FFFF);
        end else begin
          check("wrap_instr_pc", {24'd0, instr_pc}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    check("wrap_missing_instrs", exp_q.size(), 0);
    exp_q.delete();
`ifdef BORUSS_FETCH_WRAP_TRAP_EN
    check("wrap_fault", {31'd0, fetch_fault}, 32'd1);
    jump_en = 1'b1;
    jump_target = 8'h00;
    @(negedge clk);
    jump_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("fault_valid", {31'd0, instr_valid}, 32'd0);
      check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    end
    reset_dut();
    check("fault_cleared_by_rst", {31'd0, fetch_fault}, 32'd0);
`else
    check("wrap_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    // JMP 00 loop: decoder redirects on each accepted JMP
    rom[8'h00] = 8'h80;
    rom[8'h01] = 8'h00;
    reset_dut();
    instr_ready = 1'b1;
    begin
      int transfers;
      transfers = 0;
      for (int it = 0; it < 20; it++) begin
        if (it > 0) @(negedge clk);
        jump_en = 1'b0;
        check("jmp_c0_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("jmp_c1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("jmp_c2_valid", {31'd0, instr_valid}, 32'd1);
        check("jmp_instr", {8'd0, instr_opcode, instr_operand, instr_pc}, 32'h0080_0000);
        if (instr_valid && instr_ready) transfers++;
        jump_en = 1'b1;
        jump_target = instr_operand;
      end
      @(negedge clk);
      jump_en = 1'b0;
      check("jmp_transfers", transfers, 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
